// File: rtl/ball_tick_gen.sv
// ---------------------------------------------------------------------------
// ball_tick_gen
//
// Ball-speed timebase for the court. Emits a single-cycle `tick` enable that
// steps the ball one LED position. The tick period shortens by STEP on every
// return (`hit`) down to MIN_PERIOD, and goes back to BASE_PERIOD when the
// point is over (`rally_end`). Everything stays on `clock`; downstream logic
// qualifies on `tick` rather than using a divided clock.
//
// Ports:
//   clock       in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   enable      in   1      rally active; low holds the counter at 0, no ticks
//   pause       in   1      freeze counter and tick (level still updates)
//   hit         in   1      one-cycle pulse: ball returned, speed up a level
//   rally_end   in   1      one-cycle pulse: point over, level back to 0
//   tick        out  1      registered one-cycle movement enable
//   level       out  LVL_W  current speed level (0..LEVELS-1)
//   period_cur  out  CNT_W  period of the count now in progress
//   at_max      out  1      level == LEVELS-1
//
// Build option:
//   BALL_TICK_RESTART_EN  when defined, a `hit` (not masked by `rally_end`)
//                         while enabled restarts the count with the new
//                         period, realigning the tick phase to the return.
//                         When undefined, a new period only takes effect at
//                         the next natural wrap.
// ---------------------------------------------------------------------------
module ball_tick_gen #(
  parameter int               CNT_W       = 26,
  parameter int               LEVELS      = 8,
  parameter int               LVL_W       = 3,
  parameter logic [CNT_W-1:0] BASE_PERIOD = 26'h0FFFFFF,
  parameter logic [CNT_W-1:0] STEP        = 26'h0200000,
  parameter logic [CNT_W-1:0] MIN_PERIOD  = 26'h0100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pause,
  input  logic             hit,
  input  logic             rally_end,
  output logic             tick,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] period_cur,
  output logic             at_max
);

  // Wide enough that level*STEP and the subtraction from BASE_PERIOD can
  // never wrap.
  localparam int W       = CNT_W + LVL_W;
  localparam int N_CODES = 2 ** LVL_W;

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // max(BASE_PERIOD - lvl*STEP, MIN_PERIOD), truncated to the counter width.
  function automatic logic [CNT_W-1:0] target_of(input int lvl);
    logic [W-1:0] base_w;
    logic [W-1:0] step_w;
    logic [W-1:0] min_w;
    logic [W-1:0] prod_w;
    logic [W-1:0] diff_w;
    base_w = W'(BASE_PERIOD);
    step_w = W'(STEP);
    min_w  = W'(MIN_PERIOD);
    prod_w = W'(lvl) * step_w;
    if (prod_w >= base_w) begin
      diff_w = '0;
    end else begin
      diff_w = base_w - prod_w;
    end
    if (diff_w < min_w) begin
      diff_w = min_w;
    end
    return diff_w[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] RESET_PERIOD = target_of(0);

  // -------------------------------------------------------------------------
  // Per-level target period table. Every level code is a constant, so this
  // folds to a small lookup instead of a run-time multiplier. Codes above
  // LEVELS-1 are unreachable; they repeat the top level's period so the
  // table is fully defined.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] target_tab [N_CODES];

  genvar gi;
  generate
    for (gi = 0; gi < N_CODES; gi++) begin : g_target_tab
      localparam int LVL_SAT = (gi < LEVELS) ? gi : (LEVELS - 1);
      assign target_tab[gi] = target_of(LVL_SAT);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] period_next;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             tick_reg;
  logic             tick_next;

  logic [CNT_W-1:0] target_cur;
  logic             wrap;

  // Period for the level currently held; this is what a wrap (or the
  // disabled reload) picks up.
  assign target_cur = target_tab[level_reg];
  assign wrap       = (count_reg == (period_reg - CNT_ONE));

`ifdef BALL_TICK_RESTART_EN
  logic [CNT_W-1:0] target_hit;
  logic             restart;

  // A restart takes the period of the level the hit is moving to, so the
  // realigned count runs at the new speed straight away.
  assign target_hit = target_tab[level_next];
  assign restart    = enable && hit && !rally_end;
`endif

  // -------------------------------------------------------------------------
  // Level: rally_end has priority over hit; hit saturates at the top level.
  // Independent of enable/pause so the rally controller is never ignored.
  // -------------------------------------------------------------------------
  always_comb begin
    level_next = level_reg;
    if (rally_end) begin
      level_next = '0;
    end else if (hit && (level_reg != LVL_MAX)) begin
      level_next = level_reg + LVL_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Period counter and tick.
  // The period in progress is latched in period_reg and only replaced at a
  // wrap, so a speed change never shortens or stretches a count mid-flight.
  // A disabled counter tracks the target every cycle so the first period
  // after enable already reflects the current level.
  // -------------------------------------------------------------------------
  always_comb begin
    count_next  = count_reg;
    period_next = period_reg;
    tick_next   = 1'b0;
    if (!enable) begin
      count_next  = '0;
      period_next = target_cur;
`ifdef BALL_TICK_RESTART_EN
    end else if (restart) begin
      // Aborted period: drop the partial count without issuing a tick.
      count_next  = '0;
      period_next = target_hit;
`endif
    end else if (!pause) begin
      if (wrap) begin
        count_next  = '0;
        period_next = target_cur;
        tick_next   = 1'b1;
      end else begin
        count_next  = count_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= '0;
      period_reg <= RESET_PERIOD;
      level_reg  <= '0;
      tick_reg   <= 1'b0;
    end else begin
      count_reg  <= count_next;
      period_reg <= period_next;
      level_reg  <= level_next;
      tick_reg   <= tick_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tick       = tick_reg;
  assign level      = level_reg;
  assign period_cur = period_reg;
  assign at_max     = (level_reg == LVL_MAX);

endmodule
